sysid_info_regs: RTL



---
 rtl/sysid_info_pkg.sv | 22 ++
 rtl/sysid_info_regs_seconds_timer.sv | 39 +++
 rtl/sysid_info_regs.sv | 121 ++++++++++++
 3 files changed

// File: rtl/sysid_info_pkg.sv
// Shared constants for the system-identification register block.
// Holds the data width, the word-address map and the CTRL clear bit
// position so the top module and any software-facing tooling agree on
// one register map.
package sysid_info_pkg;

    localparam int DATA_W = 32;

    // Word addresses, zero-extended to the data width so they compare
    // directly against a widened bus address of any ADDR_W.
    localparam logic [DATA_W-1:0] ADDR_ID        = 32'd0;
    localparam logic [DATA_W-1:0] ADDR_TIMESTAMP = 32'd1;
    localparam logic [DATA_W-1:0] ADDR_CAPS      = 32'd2;
    localparam logic [DATA_W-1:0] ADDR_SCRATCH   = 32'd3;
    localparam logic [DATA_W-1:0] ADDR_UPTIME_LO = 32'd4;
    localparam logic [DATA_W-1:0] ADDR_UPTIME_HI = 32'd5;
    localparam logic [DATA_W-1:0] ADDR_SECONDS   = 32'd6;
    localparam logic [DATA_W-1:0] ADDR_CTRL      = 32'd7;

    localparam int CTRL_CLEAR_BIT = 0;

endpackage

// File: rtl/sysid_info_regs_seconds_timer.sv
// sysid_seconds_timer: prescaler plus 32-bit seconds counter.
// The prescaler counts 0..CLK_HZ-1; on its terminal count it returns to 0
// and the seconds counter increments (wrapping at 2^32).
// Ports:
//   clock   in   system clock
//   reset   in   synchronous active-high reset
//   clear   in   synchronous clear of prescaler and seconds (software CTRL)
//   seconds out  current seconds count
module sysid_seconds_timer
    import sysid_info_pkg::*;
#(
    parameter int CLK_HZ = 50000000
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              clear,
    output logic [DATA_W-1:0] seconds
);

    localparam int            PW        = (CLK_HZ > 2) ? $clog2(CLK_HZ) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_HZ - 1);

    logic [PW-1:0] prescaler;

    // NOTE: sequential state is assigned with <= so every register samples
    // the pre-edge values of its neighbours, independent of block order.
    always_ff @(posedge clock) begin
        if (reset || clear) begin
            prescaler <= '0;
            seconds   <= '0;
        end else if (prescaler == PRESC_MAX) begin
            prescaler <= '0;
            seconds   <= seconds + 32'd1;
        end else begin
            prescaler <= prescaler + PW'(1);
        end
    end

endmodule

// File: rtl/sysid_info_regs.sv
// sysid_info_regs: Avalon-MM system-identification slave.
// Returns build identity (ID, timestamp, capability word), a 64-bit uptime
// counter read coherently via a LO-read snapshot of the HI word, a seconds
// counter and a software scratch register. Read latency is one cycle.
// Ports:
//   clock, reset        system clock, synchronous active-high reset
//   address             word address (words beyond the map read as 0)
//   read, write         access strobes
//   writedata           write data
//   byteenable          byte lanes for writes (SCRATCH only)
//   readdata            read data, valid with readdatavalid
//   readdatavalid       one-cycle pulse one cycle after an accepted read
//   waitrequest         always 0
module sysid_info_regs
    import sysid_info_pkg::*;
#(
    parameter logic [31:0] SYSTEM_ID   = 32'h0000_0000,
    parameter logic [31:0] TIMESTAMP   = 32'd1393012022,
    parameter logic [31:0] CAPS        = 32'h0000_0000,
    parameter int          CLK_HZ      = 50000000,
    parameter int          ADDR_W      = 3,
    parameter logic [31:0] SCRATCH_RST = 32'h0000_0000
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [ADDR_W-1:0] address,
    input  logic              read,
    input  logic              write,
    input  logic [DATA_W-1:0] writedata,
    input  logic [3:0]        byteenable,
    output logic [DATA_W-1:0] readdata,
    output logic              readdatavalid,
    output logic              waitrequest
);

    logic [DATA_W-1:0] word_addr;
    logic              rd_en;
    logic              ctrl_clear;
    logic [63:0]       uptime;
    logic [DATA_W-1:0] hi_snap;
    logic [DATA_W-1:0] scratch;
    logic [DATA_W-1:0] seconds;
    logic [DATA_W-1:0] rd_mux;

    assign waitrequest = 1'b0;
    assign word_addr   = DATA_W'(address);

    // A simultaneous read and write is illegal master behaviour; the write
    // wins and the read is dropped so no stray readdatavalid is produced.
    assign rd_en      = read && !write;
    assign ctrl_clear = write && (word_addr == ADDR_CTRL) && writedata[CTRL_CLEAR_BIT];

    sysid_seconds_timer #(
        .CLK_HZ (CLK_HZ)
    ) u_timer (
        .clock   (clock),
        .reset   (reset),
        .clear   (ctrl_clear),
        .seconds (seconds)
    );

    always_ff @(posedge clock) begin
        if (reset || ctrl_clear) begin
            uptime <= '0;
        end else begin
            uptime <= uptime + 64'd1;
        end
    end

    // The upper half is captured on a LO read so a following HI read
    // pairs with the same 64-bit sample.
    always_ff @(posedge clock) begin
        if (reset || ctrl_clear) begin
            hi_snap <= '0;
        end else if (rd_en && (word_addr == ADDR_UPTIME_LO)) begin
            hi_snap <= uptime[63:32];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            scratch <= SCRATCH_RST;
        end else if (write && (word_addr == ADDR_SCRATCH)) begin
            for (int i = 0; i < 4; i++) begin
                if (byteenable[i]) begin
                    scratch[8*i +: 8] <= writedata[8*i +: 8];
                end
            end
        end
    end

    // NOTE: the default assignment first keeps this block purely
    // combinational; without it the unmatched addresses would infer a latch.
    always_comb begin
        rd_mux = '0;
        case (word_addr)
            ADDR_ID:        rd_mux = SYSTEM_ID;
            ADDR_TIMESTAMP: rd_mux = TIMESTAMP;
            ADDR_CAPS:      rd_mux = CAPS;
            ADDR_SCRATCH:   rd_mux = scratch;
            ADDR_UPTIME_LO: rd_mux = uptime[31:0];
            ADDR_UPTIME_HI: rd_mux = hi_snap;
            ADDR_SECONDS:   rd_mux = seconds;
            default:        rd_mux = '0;
        endcase
    end

    // readdata holds its last value between reads.
    always_ff @(posedge clock) begin
        if (reset) begin
            readdata      <= '0;
            readdatavalid <= 1'b0;
        end else begin
            readdatavalid <= rd_en;
            if (rd_en) begin
                readdata <= rd_mux;
            end
        end
    end

endmodule
